// File: rtl/gcn_counter_pkg.sv
// Shared types and default widths for the GCN index counters.
package gcn_counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } nest_state_t;

    localparam int DEFAULT_NUM_LEVELS  = 3;
    localparam int DEFAULT_COUNT_WIDTH = 8;

endpackage

// File: rtl/loop_level_counter.sv
// One level of the loop nest: counts 0..bound inclusive, wraps to 0 when stepped at bound.
module loop_level_counter #(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   step,
    input  logic [COUNT_WIDTH-1:0] bound,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   at_bound
);

    // Equality compare keeps a full-width bound legal with no overflow path.
    assign at_bound = (count == bound);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (step) begin
            if (at_bound) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/loop_nest_counter.sv
// Cascaded NUM_LEVELS loop-nest counter with start/busy/done handshake.
// Define LOOP_NEST_COUNTER_ABORT_EN to add the abort input.
module loop_nest_counter
    import gcn_counter_pkg::*;
#(
    parameter int NUM_LEVELS  = DEFAULT_NUM_LEVELS,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset,
`ifdef LOOP_NEST_COUNTER_ABORT_EN
    input  logic                              abort,
`endif
    input  logic                              start,
    input  logic [NUM_LEVELS*COUNT_WIDTH-1:0] bounds,
    input  logic                              advance,
    output logic [NUM_LEVELS*COUNT_WIDTH-1:0] count,
    output logic [NUM_LEVELS-1:0]             level_wrap,
    output logic                              last,
    output logic                              busy,
    output logic                              done
);

    // Handshake: start is accepted only while busy=0; busy stays high for the
    // whole run, each cycle with advance=1 in RUN is one innermost step, and
    // done pulses for one cycle after the step taken while last=1.

    nest_state_t state, state_next;

    logic [NUM_LEVELS*COUNT_WIDTH-1:0] bound_q;
    logic [NUM_LEVELS-1:0]             at_bound;
    logic [NUM_LEVELS-1:0]             step_en;
    logic                              in_run;
    logic                              abort_now;
    logic                              accept_start;
    logic                              step_ok;
    logic                              final_step;
    logic                              clear;
    logic                              done_q;

`ifdef LOOP_NEST_COUNTER_ABORT_EN
    assign abort_now = abort;
`else
    assign abort_now = 1'b0;
`endif

    assign in_run       = (state == RUN);
    assign accept_start = (state == IDLE) && start;
    assign step_ok      = in_run && advance && !abort_now;
    assign clear        = accept_start || (in_run && abort_now);

    // Carry chain: a level steps when every inner level sits at its bound.
    assign step_en[0] = step_ok;
    for (genvar i = 1; i < NUM_LEVELS; i++) begin : g_carry
        assign step_en[i] = step_en[i-1] && at_bound[i-1];
    end

    for (genvar i = 0; i < NUM_LEVELS; i++) begin : g_level
        loop_level_counter #(
            .COUNT_WIDTH (COUNT_WIDTH)
        ) u_level (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear),
            .step     (step_en[i]),
            .bound    (bound_q[i*COUNT_WIDTH +: COUNT_WIDTH]),
            .count    (count[i*COUNT_WIDTH +: COUNT_WIDTH]),
            .at_bound (at_bound[i])
        );
    end

    assign level_wrap = step_en & at_bound;
    assign last       = in_run && !abort_now && (&at_bound);
    assign final_step = level_wrap[NUM_LEVELS-1];

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort_now || final_step) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bound_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= final_step;
            if (accept_start) begin
                bound_q <= bounds;
            end
        end
    end

    assign busy = in_run;
    assign done = done_q;

endmodule
